// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC main-memory handshake block.
//   - SIZE encodings (byte / halfword / word; 2'b11 behaves as word)
//   - FSM state encodings
//   - RW direction constants
//   - latched request struct and an alignment helper
package sparc_mem_pkg;

  localparam int NUM_LANES = 4;  // byte lanes in a 32-bit word

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

  // Request fields captured on the accept edge (address kept separately,
  // since its width follows the memory depth).
  typedef struct packed {
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
  } mem_req_t;

  // Halfword needs addr[0]=0; word (and the 2'b11 alias) needs addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] a);
    if (size[1])         return (a != 2'b00);
    if (size == SZ_HALF) return a[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/sparc_mem_array.sv
// Byte-wide storage of DEPTH bytes with a 4-lane big-endian port.
//   Clk    : write clock
//   we     : per-lane write enables, we[3] = byte at addr, we[0] = addr+3
//   addr   : base byte address (wraps modulo DEPTH)
//   wdata  : write data, lane 3 = bits [31:24]
//   rdata  : asynchronous read of {ram[addr], .., ram[addr+3]}
// ram[] is left without reset so contents survive Reset and can be
// preloaded hierarchically.
module sparc_mem_array
  import sparc_mem_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic                          Clk,
  input  logic [NUM_LANES-1:0]          we,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [NUM_LANES-1:0][7:0]     wdata,
  output logic [NUM_LANES-1:0][7:0]     rdata
);

  logic [7:0]        ram [DEPTH];
  logic [ADDR_W-1:0] lane_addr [NUM_LANES];

  // Lane g holds byte offset (NUM_LANES-1-g): the highest lane is the
  // lowest address, which gives big-endian ordering in the packed word.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_addr[g] = addr + ADDR_W'(NUM_LANES - 1 - g);
    assign rdata[g]     = ram[lane_addr[g]];
  end

  always_ff @(posedge Clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (we[i]) ram[lane_addr[i]] <= wdata[i];
  end

endmodule

// File: rtl/sparc_mem_handshake.sv
// Big-endian byte-addressed main memory with MFA/MFC handshake.
//   Clk, Reset : clock, async active-high reset
//   MFA        : request, held until MFC seen
//   RW         : 1 read, 0 write
//   SIZE       : 00 byte, 01 half, 10/11 word
//   SIGNED     : sign-extend byte/half reads
//   ADDR       : byte address (low ADDR_W bits used, wraps)
//   DATA_IN    : right-justified write data
//   DATA_OUT   : last successful read value (registered)
//   MFC        : completion, high in DONE
//   ALIGN_ERR  : misaligned flag, valid while MFC=1
// Request is latched in IDLE, executes LATENCY edges later, then DONE
// holds MFC until MFA is sampled low.
module sparc_mem_handshake
  import sparc_mem_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MFA,
  input  logic        RW,
  input  logic [1:0]  SIZE,
  input  logic        SIGNED,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        MFC,
  output logic        ALIGN_ERR
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  mem_req_t          req_q;
  logic [ADDR_W-1:0] addr_q;

  mem_req_t          cur;
  logic [ADDR_W-1:0] cur_addr;
  logic              exec;
  logic              mis;
  logic [NUM_LANES-1:0]      we;
  logic [NUM_LANES-1:0][7:0] wdata;
  logic [NUM_LANES-1:0][7:0] rdata;
  logic [31:0]       rd_ext;

  // Upper address bits are intentionally ignored (modulo-DEPTH wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^ADDR[31:ADDR_W];

  // With LATENCY=1 the access executes on the accept edge itself, so the
  // live inputs feed the datapath while still in IDLE.
  always_comb begin
    cur      = req_q;
    cur_addr = addr_q;
    if (state == ST_IDLE) begin
      cur      = '{rw: RW, size: SIZE, sgn: SIGNED, wdata: DATA_IN};
      cur_addr = ADDR[ADDR_W-1:0];
    end
  end

  assign exec = (LATENCY == 1) ? (state == ST_IDLE && MFA)
                               : (state == ST_BUSY && cnt == '0);
  assign mis  = is_misaligned(cur.size, cur_addr[1:0]);

  // Write lane steering: narrow data lands in the top lanes (lowest address).
  always_comb begin
    we    = '0;
    wdata = cur.wdata;
    if (cur.size[1]) begin
      we = 4'b1111;
    end else if (cur.size == SZ_HALF) begin
      we    = 4'b1100;
      wdata = {cur.wdata[15:0], 16'h0000};
    end else begin
      we    = 4'b1000;
      wdata = {cur.wdata[7:0], 24'h000000};
    end
    if (!exec || mis || cur.rw != MEM_WR) we = '0;
  end

  always_comb begin
    rd_ext = rdata;
    if (cur.size == SZ_BYTE)
      rd_ext = {{24{cur.sgn & rdata[3][7]}}, rdata[3]};
    else if (cur.size == SZ_HALF)
      rd_ext = {{16{cur.sgn & rdata[3][7]}}, rdata[3], rdata[2]};
  end

  sparc_mem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
    .Clk   (Clk),
    .we    (we),
    .addr  (cur_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      addr_q    <= '0;
      MFC       <= 1'b0;
      DATA_OUT  <= '0;
      ALIGN_ERR <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (MFA) begin
          req_q  <= cur;
          addr_q <= cur_addr;
          cnt    <= CNT_W'(LATENCY - 1);
          state  <= (LATENCY == 1) ? ST_DONE : ST_BUSY;
        end
        ST_BUSY: begin
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        ST_DONE: if (!MFA) begin
          state <= ST_IDLE;
          MFC   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      // exec never coincides with DONE, so no conflict with the MFC clear.
      if (exec) begin
        MFC       <= 1'b1;
        ALIGN_ERR <= mis;
        if (!mis && cur.rw == MEM_RD) DATA_OUT <= rd_ext;
      end
    end
  end

endmodule
